// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter driving the select and one-hot grant of a shared 8:1 mux.
// Define ARB_TIMEOUT_EN to force release of a grant held for MAX_HOLD cycles.
module mux8_rr_arbiter #(
    parameter int unsigned N_REQ    = 8,
    parameter int unsigned SEL_W    = $clog2(N_REQ),
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [SEL_W-1:0] sel,
    output logic             sel_vld,
    output logic             timeout
);

    if (N_REQ != 8 || SEL_W != 3 || MAX_HOLD < 2) begin : g_bad_cfg
        $error("mux8_rr_arbiter: N_REQ must be 8, SEL_W 3, MAX_HOLD >= 2");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic              sel_vld_q, sel_vld_d;

    logic              win_found;
    logic [SEL_W-1:0]  win_idx;
    logic [SEL_W-1:0]  cand;
    logic              expire;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned HOLD_W = $clog2(MAX_HOLD) + 1;

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              timeout_q, timeout_d;

    assign expire  = (hold_q == HOLD_W'(MAX_HOLD - 1));
    assign timeout = timeout_q;

    // Counter parks at zero while idle, so it is already clear on entering GRANT.
    always_comb begin
        hold_d    = hold_q;
        timeout_d = 1'b0;
        if (state_q == IDLE) begin
            hold_d = '0;
        end else if (req[sel_q] && expire) begin
            timeout_d = 1'b1;
        end else begin
            hold_d = hold_q + HOLD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end
`else
    assign expire  = 1'b0;
    assign timeout = 1'b0;
`endif

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = ptr_q + SEL_W'(k);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        sel_d     = sel_q;
        sel_vld_d = sel_vld_q;
        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d          = GRANT;
                    gnt_d            = '0;
                    gnt_d[win_idx]   = 1'b1;
                    sel_d            = win_idx;
                    sel_vld_d        = 1'b1;
                end
            end
            GRANT: begin
                // Owner dropping req and hold expiry release the same way; sel keeps the last owner.
                if (!req[sel_q] || expire) begin
                    state_d   = IDLE;
                    gnt_d     = '0;
                    sel_vld_d = 1'b0;
                    ptr_d     = sel_q + SEL_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            gnt_q     <= '0;
            sel_q     <= '0;
            sel_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            sel_q     <= sel_d;
            sel_vld_q <= sel_vld_d;
        end
    end

    assign gnt     = gnt_q;
    assign sel     = sel_q;
    assign sel_vld = sel_vld_q;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed self-checking bench for mux8_rr_arbiter; covers ARB_TIMEOUT_EN on and off.
module tb_mux8_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       sel_vld;
    logic       timeout;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    always #5 clk = ~clk;

    mux8_rr_arbiter #(
        .N_REQ    (8),
        .SEL_W    (3),
        .MAX_HOLD (16)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .gnt     (gnt),
        .sel     (sel),
        .sel_vld (sel_vld),
        .timeout (timeout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [7:0] g, input logic [2:0] s,
                              input logic v, input logic t);
        check({tag, ".gnt"},     32'(gnt),     32'(g));
        check({tag, ".sel"},     32'(sel),     32'(s));
        check({tag, ".sel_vld"}, 32'(sel_vld), 32'(v));
        check({tag, ".timeout"}, 32'(timeout), 32'(t));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after a rising edge; finishes well before the next one.
    task automatic do_reset();
        rst_n = 1'b0;
        req   = 8'h00;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] g;
        int unsigned k;

        // Reset with all requests high: outputs stay clear until the first edge after release.
        rst_n = 1'b1;
        req   = 8'hFF;
        #1;
        rst_n = 1'b0;
        #22;
        expect_out("rst_hold", 8'h00, 3'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        #1;
        expect_out("rst_rel", 8'h00, 3'd0, 1'b0, 1'b0);
        tick();
        expect_out("rst_first", 8'h01, 3'd0, 1'b1, 1'b0);

        // Single request, other requests ignored, release, then pointer skip to 7 and wrap to 0.
        do_reset();
        req = 8'h04;
        tick();
        expect_out("single_gnt", 8'h04, 3'd2, 1'b1, 1'b0);
        req = 8'h06;
        tick();
        expect_out("single_ignore", 8'h04, 3'd2, 1'b1, 1'b0);
        req = 8'h00;
        tick();
        expect_out("single_rel", 8'h00, 3'd2, 1'b0, 1'b0);
        tick();
        expect_out("single_idle", 8'h00, 3'd2, 1'b0, 1'b0);
        req = 8'h81;
        tick();
        expect_out("skip_7", 8'h80, 3'd7, 1'b1, 1'b0);
        req = 8'h01;
        tick();
        expect_out("skip_rel7", 8'h00, 3'd7, 1'b0, 1'b0);
        tick();
        expect_out("skip_wrap0", 8'h01, 3'd0, 1'b1, 1'b0);
        req = 8'h00;
        tick();

        // Round robin with all requesting: 0..7 then 0, one idle cycle between grants.
        do_reset();
        req = 8'hFF;
        tick();
        for (int i = 0; i < 9; i++) begin
            k = i % 8;
            g = 8'h01 << k;
            expect_out($sformatf("rr%0d_a", i), g, k[2:0], 1'b1, 1'b0);
            tick();
            expect_out($sformatf("rr%0d_b", i), g, k[2:0], 1'b1, 1'b0);
            req = ~g;
            tick();
            expect_out($sformatf("rr%0d_idle", i), 8'h00, k[2:0], 1'b0, 1'b0);
            req = 8'hFF;
            tick();
        end
        req = 8'h00;
        tick();

        // Held request: forced release after 16 cycles with the macro, indefinite hold without.
        do_reset();
        req = 8'h02;
        tick();
        expect_out("hold_c0", 8'h02, 3'd1, 1'b1, 1'b0);
        for (int j = 1; j < 16; j++) begin
            tick();
            expect_out($sformatf("hold_c%0d", j), 8'h02, 3'd1, 1'b1, 1'b0);
        end
`ifdef ARB_TIMEOUT_EN
        tick();
        expect_out("to_pulse", 8'h00, 3'd1, 1'b0, 1'b1);
        tick();
        expect_out("to_regrant", 8'h02, 3'd1, 1'b1, 1'b0);

        // Owner releases on the expiry cycle itself: normal release, no pulse.
        do_reset();
        req = 8'h02;
        tick();
        repeat (15) tick();
        expect_out("exp_last", 8'h02, 3'd1, 1'b1, 1'b0);
        req = 8'h00;
        tick();
        expect_out("exp_normal_rel", 8'h00, 3'd1, 1'b0, 1'b0);
`else
        for (int j = 16; j < 116; j++) begin
            tick();
            expect_out($sformatf("hold_c%0d", j), 8'h02, 3'd1, 1'b1, 1'b0);
        end
`endif
        req = 8'h00;
        tick();

        // Asynchronous reset while requester 5 owns the mux; pointer returns to 0.
        do_reset();
        req = 8'h08;
        tick();
        expect_out("ar_g3", 8'h08, 3'd3, 1'b1, 1'b0);
        req = 8'h00;
        tick();
        req = 8'h20;
        tick();
        expect_out("ar_g5", 8'h20, 3'd5, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        expect_out("ar_clr", 8'h00, 3'd0, 1'b0, 1'b0);
        #3;
        rst_n = 1'b1;
        req   = 8'h21;
        tick();
        expect_out("ar_ptr0", 8'h01, 3'd0, 1'b1, 1'b0);
        req = 8'h00;
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
